// File: rtl/hist_bin_ctrl.sv
`timescale 1ns/1ps
// hist_bin_ctrl: arbitrates the single-port bin RAM between sample increments, host readout and clear sweeps.
// Optional HIST_SAT_FLAG_EN adds a sticky saturation flag (sat_flag) with its clear input (sat_clr).
module hist_bin_ctrl #(
  parameter int DATA_W   = 8,
  parameter int BIN_BITS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [DATA_W-1:0]   sample_data,
  output logic                sample_ready,
  input  logic                rd_req,
  input  logic [BIN_BITS-1:0] rd_bin,
  output logic                rd_valid,
  output logic [CNT_W-1:0]    rd_data,
  input  logic                clear_start,
  output logic                clear_busy,
`ifdef HIST_SAT_FLAG_EN
  input  logic                sat_clr,
  output logic                sat_flag,
`endif
  output logic                mem_en,
  output logic                mem_we,
  output logic [BIN_BITS-1:0] mem_addr,
  output logic [CNT_W-1:0]    mem_wdata,
  input  logic [CNT_W-1:0]    mem_rdata
);

  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
  localparam logic [BIN_BITS-1:0] LAST_BIN = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INC_RD  = 3'd1,
    INC_WR  = 3'd2,
    RO_RD   = 3'd3,
    RO_DATA = 3'd4,
    CLR     = 3'd5
  } state_t;

  state_t              state;
  logic                clear_pending;
  logic [BIN_BITS-1:0] addr_q;
  logic                clr_req;
  logic                unused_low;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // A fresh clear_start in IDLE is served at once, so sample_ready must drop for it too.
  assign clr_req      = clear_pending | clear_start;
  assign sample_ready = (state == IDLE) & ~clr_req & ~rd_req;
  assign clear_busy   = clear_pending | (state == CLR);
  assign mem_addr     = addr_q;
  assign mem_wdata    = (state == INC_WR) ? sat_inc(mem_rdata) : '0;
  assign unused_low   = ^sample_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      clear_pending <= 1'b0;
      addr_q        <= '0;
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (clear_start && state != IDLE && state != CLR)
        clear_pending <= 1'b1;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state         <= CLR;
            addr_q        <= '0;
            mem_en        <= 1'b1;
            mem_we        <= 1'b1;
            clear_pending <= 1'b0;
          end else if (rd_req) begin
            state  <= RO_RD;
            addr_q <= rd_bin;
            mem_en <= 1'b1;
            mem_we <= 1'b0;
          end else if (sample_valid) begin
            state  <= INC_RD;
            addr_q <= sample_data[DATA_W-1 -: BIN_BITS];
            mem_en <= 1'b1;
            mem_we <= 1'b0;
          end
        end
        INC_RD: begin
          state  <= INC_WR;
          mem_we <= 1'b1;
        end
        INC_WR: begin
          state  <= IDLE;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
        RO_RD: begin
          state  <= RO_DATA;
          mem_en <= 1'b0;
        end
        RO_DATA: begin
          state    <= IDLE;
          rd_valid <= 1'b1;
          rd_data  <= mem_rdata;
        end
        CLR: begin
          if (addr_q == LAST_BIN) begin
            state  <= IDLE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
          end else begin
            addr_q <= addr_q + BIN_BITS'(1);
          end
        end
        default: begin
          state  <= IDLE;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

`ifdef HIST_SAT_FLAG_EN
  // Saturation is detected on the read value: the bin was already full before this increment.
  always_ff @(posedge clk) begin
    if (rst)
      sat_flag <= 1'b0;
    else if (state == INC_WR && mem_rdata == CNT_MAX)
      sat_flag <= 1'b1;
    else if (sat_clr || (state == IDLE && clr_req))
      sat_flag <= 1'b0;
  end
`endif

endmodule
